// File: rtl/alu_pipe_pkg.sv
// Shared opcode, state and flag types for the pipelined ALU and its reference users.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_SHL = 4'd0,
    OP_SHR = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_EQ  = 4'd7,
    OP_MUL = 4'd8,
    OP_ADC = 4'd9
  } opcode_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic illegal;
  } flags_t;

  // Ops whose carry feeds the next ADC.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result handshake bundle between decoder, ALU and writeback.
interface alu_pipe_if #(parameter int WIDTH = 8) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_flag;
  logic             zero_flag;
  logic             neg_flag;
  logic             ovf_flag;
  logic             illegal_op;
  logic             busy;

  modport master (
    output in_valid, opcode, data0, data1, out_ready,
    input  in_ready, out_valid, result, result_hi, carry_flag, zero_flag,
           neg_flag, ovf_flag, illegal_op, busy
  );

  modport slave (
    input  in_valid, opcode, data0, data1, out_ready,
    output in_ready, out_valid, result, result_hi, carry_flag, zero_flag,
           neg_flag, ovf_flag, illegal_op, busy
  );
endinterface

// File: rtl/alu_pipe_comb.sv
// Combinational single-cycle datapath: every opcode except MUL, which the top iterates.
module alu_pipe_comb
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_result,
  output flags_t           o_flags
);

  localparam int SHW = $clog2(WIDTH);

  logic             w_shift_oor;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_adc;
  logic             w_a_s;
  logic             w_b_s;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;

  assign w_shift_oor = i_data1 >= WIDTH'(WIDTH);
  assign w_amt       = i_data1[SHW-1:0];
  // Extra bit on the shifted-out side captures the last bit lost as carry.
  assign w_shl       = {1'b0, i_data0} << w_amt;
  assign w_shr       = {i_data0, 1'b0} >> w_amt;
  assign w_add       = {1'b0, i_data0} + {1'b0, i_data1};
  assign w_sub       = {1'b0, i_data0} - {1'b0, i_data1};
  assign w_adc       = w_add + {{WIDTH{1'b0}}, i_carry_in};
  assign w_a_s       = i_data0[WIDTH-1];
  assign w_b_s       = i_data1[WIDTH-1];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (i_opcode)
      OP_SHL: if (!w_shift_oor) begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: if (!w_shift_oor) begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (w_a_s == w_b_s) && (w_res[WIDTH-1] != w_a_s);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (w_a_s != w_b_s) && (w_res[WIDTH-1] == w_b_s);
      end
      OP_ADC: begin
        w_res = w_adc[WIDTH-1:0];
        w_c   = w_adc[WIDTH];
        w_v   = (w_a_s == w_b_s) && (w_res[WIDTH-1] != w_a_s);
      end
      OP_AND: w_res = i_data0 & i_data1;
      OP_OR:  w_res = i_data0 | i_data1;
      OP_XOR: w_res = i_data0 ^ i_data1;
      OP_EQ:  w_res = {{(WIDTH-1){1'b0}}, (i_data0 == i_data1)};
      OP_MUL: w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  assign o_result = w_res;
  assign o_flags  = '{carry: w_c, zero: (w_res == '0), neg: w_res[WIDTH-1],
                      ovf: w_v, illegal: w_ill};

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, chained carry and a shift-add multiplier.
//   state | meaning
//   IDLE  | accepting requests; single-cycle ops write results directly
//   MULT  | one shift-add step per cycle, WIDTH steps in total
//   HOLD  | product complete, waiting for the pending result to drain
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  alu_pipe_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MULT = MULT;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]         r_state;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_carry_q;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  flags_t             r_flags;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_stall;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_wr_single;
  logic               w_wr_mul;
  logic               w_wr_arith;
  logic [WIDTH-1:0]   w_comb_result;
  flags_t             w_comb_flags;
  flags_t             w_mul_flags;
  logic [WIDTH-1:0]   w_wr_result;
  logic [WIDTH-1:0]   w_wr_hi;
  flags_t             w_wr_flags;

  alu_pipe_comb #(.WIDTH(WIDTH)) u_comb (
    .i_opcode   (bus.opcode),
    .i_data0    (bus.data0),
    .i_data1    (bus.data1),
    .i_carry_in (r_carry_q),
    .o_result   (w_comb_result),
    .o_flags    (w_comb_flags)
  );

  assign bus.in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_is_mul     = (bus.opcode == OP_MUL);
  assign w_stall      = r_out_valid && !bus.out_ready;
  assign w_last       = (r_cnt == SHW'(WIDTH-1));

  // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = (r_state == S_HOLD) ? r_acc : w_acc_next;

  assign w_wr_single = w_accept && !w_is_mul;
  assign w_wr_mul    = ((r_state == S_MULT) && w_last && !w_stall) ||
                       ((r_state == S_HOLD) && bus.out_ready);
  assign w_wr_arith  = w_wr_mul || (w_wr_single && is_arith(bus.opcode));

  assign w_mul_flags = '{carry: |w_prod[2*WIDTH-1:WIDTH], zero: (w_prod[WIDTH-1:0] == '0),
                         neg: w_prod[WIDTH-1], ovf: 1'b0, illegal: 1'b0};
  assign w_wr_result = w_wr_mul ? w_prod[WIDTH-1:0] : w_comb_result;
  assign w_wr_hi     = w_wr_mul ? w_prod[2*WIDTH-1:WIDTH] : '0;
  assign w_wr_flags  = w_wr_mul ? w_mul_flags : w_comb_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_carry_q   <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_is_mul) begin
          r_state <= S_MULT;
          r_mcand <= bus.data0;
          r_acc   <= {{WIDTH{1'b0}}, bus.data1};
          r_cnt   <= '0;
        end
        S_MULT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= w_stall ? S_HOLD : S_IDLE;
        end
        S_HOLD: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_wr_single || w_wr_mul) begin
        r_out_valid <= 1'b1;
        r_result    <= w_wr_result;
        r_result_hi <= w_wr_hi;
        r_flags     <= w_wr_flags;
        if (w_wr_arith) r_carry_q <= w_wr_flags.carry;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.result     = r_result;
  assign bus.result_hi  = r_result_hi;
  assign bus.carry_flag = r_flags.carry;
  assign bus.zero_flag  = r_flags.zero;
  assign bus.neg_flag   = r_flags.neg;
  assign bus.ovf_flag   = r_flags.ovf;
  assign bus.illegal_op = r_flags.illegal;
  assign bus.busy       = (r_state == S_MULT);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe (WIDTH=8) against an arithmetic reference model.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   m_carry = 1'b0;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int op, input int a, input int b, input bit cin);
    exp_t e;
    int r = 0, hi = 0, c = 0, v = 0, ill = 0, p, s;
    int sa = (a >= 128) ? a - 256 : a;
    int sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: if (b < 8) begin r = (a << b) % 256; c = (b > 0) ? (a >> (8 - b)) & 1 : 0; end
      1: if (b < 8) begin r = a >> b; c = (b > 0) ? (a >> (b - 1)) & 1 : 0; end
      2: begin s = a + b; r = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3: begin r = (a - b + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = (a == b) ? 1 : 0;
      8: begin p = a * b; r = p % 256; hi = p / 256; c = (hi != 0); end
      9: begin
        s = a + b + int'(cin); r = s % 256; c = (s > 255);
        v = (sa + sb + int'(cin) > 127) || (sa + sb + int'(cin) < -128);
      end
      default: ill = 1;
    endcase
    e.res = 8'(r);
    e.hi  = 8'(hi);
    e.c   = (c != 0);
    e.z   = (r == 0);
    e.n   = (r >= 128);
    e.v   = (v != 0);
    e.ill = (ill != 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input exp_t e);
    chk("sb_result", bus.result, e.res);
    chk("sb_result_hi", bus.result_hi, e.hi);
    chk("sb_carry", bus.carry_flag, e.c);
    chk("sb_zero", bus.zero_flag, e.z);
    chk("sb_neg", bus.neg_flag, e.n);
    chk("sb_ovf", bus.ovf_flag, e.v);
    chk("sb_illegal", bus.illegal_op, e.ill);
  endtask

  // Drive one cycle from a negedge, score transfers, end at the next negedge.
  task automatic drive(input bit iv, input int op, input int a, input int b,
                       input bit ordy, output bit acc);
    exp_t e;
    bus.in_valid  = iv;
    bus.opcode    = op[3:0];
    bus.data0     = a[7:0];
    bus.data1     = b[7:0];
    bus.out_ready = ordy;
    #1;
    acc = iv && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("spurious_out", bus.out_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk_out(e);
      end
    end
    if (acc) begin
      e = model(op, a, b, m_carry);
      q.push_back(e);
      if (op == 2 || op == 3 || op == 8 || op == 9) m_carry = e.c;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input bit iv, input int op, input int a, input int b, input bit ordy);
    bit acc;
    drive(iv, op, a, b, ordy, acc);
  endtask

  task automatic issue(input int op, input int a, input int b);
    bit acc;
    drive(1'b1, op, a, b, 1'b1, acc);
    chk("accept", acc, 1'b1);
  endtask

  initial begin
    bit acc;
    bit pend;
    int accepted, cyc, pop, pa, pb;

    bus.in_valid = 1'b0; bus.opcode = '0; bus.data0 = '0; bus.data1 = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_result", bus.result, 8'h00);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // Add, then chained add-with-carry.
    issue(2, 200, 100);
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_result", bus.result, 8'd44);
    chk("add_carry", bus.carry_flag, 1'b1);
    chk("add_zero", bus.zero_flag, 1'b0);
    issue(9, 1, 1);
    chk("adc_result", bus.result, 8'd3);
    chk("adc_carry", bus.carry_flag, 1'b0);

    issue(3, 5, 7);
    chk("sub_result", bus.result, 8'd254);
    chk("sub_carry", bus.carry_flag, 1'b1);
    chk("sub_neg", bus.neg_flag, 1'b1);
    chk("sub_ovf", bus.ovf_flag, 1'b0);
    issue(3, 8'h80, 8'h01);
    chk("sub_ovf_result", bus.result, 8'h7F);
    chk("sub_ovf_flag", bus.ovf_flag, 1'b1);
    issue(7, 9, 9);
    chk("eq_result", bus.result, 8'd1);

    // Multiply: eight busy cycles, product on the ninth edge.
    issue(8, 255, 255);
    for (int k = 0; k < 8; k++) begin
      chk("mul_busy", bus.busy, 1'b1);
      chk("mul_in_ready", bus.in_ready, 1'b0);
      chk("mul_early_valid", bus.out_valid, 1'b0);
      go(1'b0, 0, 0, 0, 1'b1);
    end
    chk("mul_valid", bus.out_valid, 1'b1);
    chk("mul_busy_done", bus.busy, 1'b0);
    chk("mul_lo", bus.result, 8'h01);
    chk("mul_hi", bus.result_hi, 8'hFE);
    chk("mul_carry", bus.carry_flag, 1'b1);

    // Backpressure: a held result blocks the next request.
    issue(2, 1, 2);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8, 3, 5, 1'b0, acc);
      chk("bp_blocked", acc, 1'b0);
      chk("bp_stable_valid", bus.out_valid, 1'b1);
      chk("bp_stable_result", bus.result, 8'd3);
    end
    drive(1'b1, 8, 3, 5, 1'b1, acc);
    chk("bp_accept_after_consume", acc, 1'b1);
    for (int k = 0; k < 8; k++) go(1'b0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_mul_valid", bus.out_valid, 1'b1);
      chk("bp_mul_result", bus.result, 8'd15);
      go(1'b0, 0, 0, 0, 1'b0);
    end

    // Shift boundaries and an undefined opcode.
    issue(0, 8'h81, 1);
    chk("shl1", bus.result, 8'h02);
    issue(1, 8'h80, 7);
    chk("shr7", bus.result, 8'h01);
    issue(0, 8'h55, 8);
    chk("shl8_result", bus.result, 8'h00);
    chk("shl8_zero", bus.zero_flag, 1'b1);
    chk("shl8_carry", bus.carry_flag, 1'b0);
    issue(0, 8'h55, 200);
    chk("shl200_result", bus.result, 8'h00);
    chk("shl200_zero", bus.zero_flag, 1'b1);
    issue(12, 3, 4);
    chk("ill_result", bus.result, 8'h00);
    chk("ill_flag", bus.illegal_op, 1'b1);
    chk("ill_zero", bus.zero_flag, 1'b1);

    // Reset in the fourth multiply cycle after leaving carry set.
    issue(2, 255, 1);
    go(1'b0, 0, 0, 0, 1'b1);
    issue(8, 15, 17);
    for (int k = 0; k < 3; k++) go(1'b0, 0, 0, 0, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_busy", bus.busy, 1'b0);
    q.delete();
    m_carry = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    issue(9, 0, 0);
    chk("mrst_adc_result", bus.result, 8'h00);
    chk("mrst_adc_carry", bus.carry_flag, 1'b0);
    go(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      chk("mrst_no_stale", bus.out_valid, 1'b0);
      go(1'b0, 0, 0, 0, 1'b1);
    end

    // Random stream with random backpressure.
    accepted = 0; cyc = 0; pend = 1'b0; pop = 0; pa = 0; pb = 0;
    while (accepted < 1000 && cyc < 40000) begin
      if (!pend && $urandom_range(9) < 7) begin
        pend = 1'b1;
        pop  = $urandom_range(15);
        pa   = $urandom_range(255);
        pb   = ($urandom_range(3) == 0) ? $urandom_range(10) : $urandom_range(255);
      end
      drive(pend, pop, pa, pb, $urandom_range(9) < 7, acc);
      if (acc) begin
        pend = 1'b0;
        accepted++;
      end
      cyc++;
    end
    chk("stream_accepted", accepted, 1000);
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      go(1'b0, 0, 0, 0, 1'b1);
      cyc++;
    end
    chk("drain_empty", q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      chk("drain_idle", bus.out_valid, 1'b0);
      go(1'b0, 0, 0, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a persistent carry register for chained add-with-carry, extra flags (negative, overflow, illegal opcode), and a multi-cycle shift-add multiplier.
- Sits between the instruction decoder/register file and writeback. Generalised to WIDTH bits.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), number of low data1 bits significant for shift-amount range checks (derived, localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- opcode  in  4  operation select, see Behaviour.
- data0  in  WIDTH  operand A.
- data1  in  WIDTH  operand B / shift amount.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes result.
- result  out  WIDTH  result, low half for MUL.
- result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- carry_flag  out  1  carry/borrow of the delivered result.
- zero_flag  out  1  result == 0 (result_hi is ignored).
- neg_flag  out  1  result[WIDTH-1].
- ovf_flag  out  1  signed overflow for ADD/SUB/ADC, else 0.
- illegal_op  out  1  delivered result came from an undefined opcode.
- busy  out  1  multiply in progress.

Behaviour:
- Opcodes:
  - 0 SHL, 1 SHR (logical); shift amount data1 >= WIDTH gives 0, carry 0.
  - 2 ADD, 3 SUB (carry = borrow, data0 < data1 unsigned).
  - 4 AND, 5 OR, 6 XOR.
  - 7 EQ: result = 1 if data0 == data1, else 0.
  - 8 MUL (unsigned, {result_hi, result} = data0*data1, carry = |result_hi).
  - 9 ADC: data0 + data1 + carry_q.
  - 10-15 illegal: result 0, all flags 0 except zero_flag = 1, illegal_op = 1.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready), which allows full throughput of 1 op/cycle for single-cycle ops.
- Latency:
  - Single-cycle ops: result valid on the edge after acceptance, out_valid = 1 the next cycle.
  - MUL: WIDTH cycles of iteration, then out_valid, so acceptance to out_valid = WIDTH+1 edges.
- FSM: IDLE, MULT, HOLD.
  - IDLE: accepting MUL -> MULT, loading multiplicand/multiplier/accumulator and counter = 0. Other ops write output registers and stay in IDLE.
  - MULT: one shift-add step per cycle, busy = 1, in_ready = 0. When counter == WIDTH-1, -> HOLD if out_valid && !out_ready (prior result still pending), else write the output registers and -> IDLE.
  - HOLD: the completed product waits internally; when the pending output is consumed, write the product and -> IDLE.
- Output registers and out_valid update only on an output write. While out_valid && !out_ready, all output ports stay stable.
- carry_q (internal):
  - Updated only when an ADD/SUB/ADC/MUL result is written; equals that result's carry_flag.
  - ADC samples carry_q at acceptance. Back-to-back ADC uses the carry of the immediately preceding arithmetic result, not a stale value.
- ovf_flag:
  - ADD/ADC: operands same sign, result sign differs.
  - SUB: operands differ in sign, result sign equals data1 sign.
- Reset (async, any state incl. mid-MUL): state = IDLE; out_valid, busy, carry_q, all flags, result, result_hi = 0. Any in-flight MUL is discarded, no partial output. in_ready = 1 after reset deasserts.
- Inputs are sampled only at acceptance; operand changes during MULT have no effect.

Decomposition:
- Package alu_pipe_pkg:
  - opcode_e enum (OP_SHL … OP_ADC) and OP_ILLEGAL_MIN = 10.
  - state_e (IDLE, MULT, HOLD).
  - flags_t struct {carry, zero, neg, ovf, illegal}.
- One sub-module, alu_pipe_comb: purely combinational single-cycle datapath (opcode, data0, data1, carry_in -> result, flags_t), reusable by the verifier's reference model.
- FSM, multiplier and output registers stay in alu_pipe.

Test Plan (WIDTH=8):
- Reset, then ADD 200+100 -> next cycle out_valid = 1, result = 44, carry = 1, zero = 0; then ADC 1+1 -> result = 3, carry = 0.
- SUB 5-7 -> result = 254, carry = 1, neg = 1, ovf = 0. SUB 0x80-0x01 -> result = 0x7F, ovf = 1. EQ 9,9 -> result = 1.
- MUL 255*255 -> out_valid exactly 9 edges after acceptance; result = 0x01, result_hi = 0xFE, carry = 1; busy = 1 and in_ready = 0 during all 8 MULT cycles.
- Backpressure: hold out_ready = 0, issue ADD 1+2 then a MUL -> second op accepted only after the first is consumed; outputs stable while stalled; no result lost or duplicated over a 1000-op random stream checked against alu_pipe_comb.
- Shift boundaries: SHL 0x81 by 1 -> 0x02; SHR 0x80 by 7 -> 0x01; SHL by 8 and by 200 -> 0, zero = 1. Opcode 12 -> result 0, illegal_op = 1.
- Assert rst during cycle 4 of MUL 15*17 -> immediately out_valid = 0, busy = 0, carry_q = 0; after release in_ready = 1 and no stale product ever appears.
